// File: rtl/key_conditioner.sv
`timescale 1ns/1ps
// key_conditioner: conditions one raw switch/KEY level for simpleFSM.
// Stages: polarity fix, 2-flop synchronizer, debounce FSM with registered
// outputs (w = clean level, pulse = press strobe, bouncing = FSM settling).
// Optional feature macro: KEY_REPEAT_EN (auto-repeat pulses while held).
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit ACTIVE_LOW_IN   = 1'b1,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic w,
  output logic pulse,
  output logic bouncing
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Both lengths must be at least 2 for the counters to make sense.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("key_conditioner: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, WAIT_HI, HIGH, WAIT_LO} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pulse_nxt;
  logic             in_p0;
  logic             sync_p0, sync_p1;

  // Debounce counter saturates instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Stage 0: polarity fix so that 1 always means pressed.
  assign in_p0 = key_in ^ ACTIVE_LOW_IN;

  // Stage 1-2: two-flop synchronizer; sync_p1 is the only level the FSM sees.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= in_p0;
      sync_p1 <= sync_p0;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt, rpt_nxt;
`endif

  // Next-state, debounce count and strobe decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (sync_p1) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (!sync_p1) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc(cnt);
        end
      end
      HIGH: begin
        if (!sync_p1) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (sync_p1) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc(cnt);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
`ifdef KEY_REPEAT_EN
    // Repeat timer: cleared on a fresh press, runs in HIGH, frozen in WAIT_LO
    // so a short release glitch neither restarts nor re-reports the press.
    rpt_nxt = rpt;
    if (state == WAIT_HI && state_nxt == HIGH) begin
      rpt_nxt = '0;
    end else if (state == HIGH) begin
      if (rpt == RPT_LAST) begin
        rpt_nxt   = '0;
        pulse_nxt = 1'b1;
      end else begin
        rpt_nxt = rpt + 1'b1;
      end
    end else if (state == IDLE) begin
      rpt_nxt = '0;
    end
`endif
  end

  // Stage 3: FSM state and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      w        <= 1'b0;
      pulse    <= 1'b0;
      bouncing <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      w        <= (state_nxt == HIGH) || (state_nxt == WAIT_LO);
      pulse    <= pulse_nxt;
      bouncing <= (state_nxt == WAIT_HI) || (state_nxt == WAIT_LO);
    end
  end

`ifdef KEY_REPEAT_EN
  // Repeat timer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rpt <= '0;
    else        rpt <= rpt_nxt;
  end
`endif

endmodule
